// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake.
// Optional round-key cache with replay, enabled by defining AES_KEYEXP_CACHE_EN.
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         busy,
    input  logic         replay
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant used to derive key idx+1 from key idx.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state, state_nxt;
    logic         accept, xfer, last_xfer, start_replay, replaying;
    logic [127:0] next_key, cached_first, cached_next;
    logic [31:0]  w0, w1, w2, w3, n0, n1, n2, n3;

    assign accept    = key_valid && (state == IDLE);
    assign xfer      = rk_valid && rk_ready;
    assign last_xfer = xfer && (rk_idx == 4'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept || start_replay) state_nxt = EMIT;
            EMIT:    if (last_xfer)              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state == IDLE);
        busy      = (state != IDLE);
        rk_valid  = (state == EMIT);
        rk_last   = (state == EMIT) && (rk_idx == 4'd10);
    end

    assign w0 = rk_out[127:96];
    assign w1 = rk_out[95:64];
    assign w2 = rk_out[63:32];
    assign w3 = rk_out[31:0];
    assign n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rk_idx), 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

`ifdef AES_KEYEXP_CACHE_EN
    logic [127:0] cache [0:10];
    logic         cache_ok;

    assign start_replay = (state == IDLE) && !key_valid && replay && cache_ok;
    assign cached_first = cache[0];
    assign cached_next  = cache[rk_idx + 4'd1];

    always_ff @(posedge clk) begin
        if (xfer) cache[rk_idx] <= rk_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_ok  <= 1'b0;
            replaying <= 1'b0;
        end else if (accept) begin
            cache_ok  <= 1'b0;
            replaying <= 1'b0;
        end else if (start_replay) begin
            replaying <= 1'b1;
        end else if (last_xfer) begin
            cache_ok  <= 1'b1;
        end
    end
`else
    // replay is kept on the port but has no effect in this build.
    assign start_replay = replay & 1'b0;
    assign replaying    = 1'b0;
    assign cached_first = '0;
    assign cached_next  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_out <= '0;
            rk_idx <= '0;
        end else if (accept) begin
            rk_out <= key_in;
            rk_idx <= 4'd0;
        end else if (start_replay) begin
            rk_out <= cached_first;
            rk_idx <= 4'd0;
        end else if (xfer && rk_idx != 4'd10) begin
            rk_out <= replaying ? cached_next : next_key;
            rk_idx <= rk_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand; the reference schedule is built from
// GF(2^8) arithmetic rather than a stored S-box table.
module tb_aes_key_expand;

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] OTHER  = 128'hdeadbeef0123456789abcdeffedcba98;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, key_valid, key_ready, rk_valid, rk_ready, rk_last, busy, replay;
    logic [127:0] key_in, rk_out;
    logic [3:0]   rk_idx;

    int           tests = 0;
    int           fails = 0;
    bit           rand_bp = 1'b0;
    int           stall_left = 0;
    exp_t         q[$];
    logic [7:0]   sbox_ref [256];
    logic [127:0] sched [11];

    aes_key_expand dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
        .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy), .replay(replay)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_ref[x] = s;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        // Published FIPS-197 values take precedence over the model where known.
        if (k == A1_KEY) begin sched[1] = A1_R1; sched[10] = A1_R10; end
        if (k == C_KEY)  sched[10] = C_R10;
    endtask

    task automatic push_sched();
        for (int r = 0; r < 11; r++) q.push_back(exp_t'{idx: 4'(r), key: sched[r]});
    endtask

    // Driven just after each rising edge: random, a 3-cycle stall at idx 4, or always ready.
    always @(posedge clk) begin
        #1;
        if (rand_bp) rk_ready = ($urandom_range(0, 3) != 0);
        else if (stall_left > 0 && rk_valid && rk_idx == 4'd4) begin
            rk_ready = 1'b0;
            stall_left--;
        end else rk_ready = 1'b1;
    end

    bit           stall_prev = 1'b0;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    exp_t         e;

    always @(negedge clk) begin
        if (rst) stall_prev <= 1'b0;
        else begin
            if (stall_prev) begin
                check("stall_out", rk_out, prev_out);
                check("stall_idx", 128'(rk_idx), 128'(prev_idx));
                check("stall_valid", 128'(rk_valid), 128'd1);
            end
            check("rk_last", 128'(rk_last), 128'(rk_valid && rk_idx == 4'd10));
            if (rk_valid && rk_ready) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rk: got idx %0d key %h, expected nothing", rk_idx, rk_out);
                end else begin
                    e = q.pop_front();
                    check("rk_idx", 128'(rk_idx), 128'(e.idx));
                    check("rk_out", rk_out, e.key);
                end
            end
            stall_prev <= rk_valid && !rk_ready;
            prev_out   <= rk_out;
            prev_idx   <= rk_idx;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (key_ready !== 1'b1 && n < 300) begin @(posedge clk); #2; n++; end
        if (n >= 300) check("wait_key_ready", 128'(key_ready), 128'd1);
    endtask

    // Offer a key (optionally with replay high too) and check 1-cycle latency.
    task automatic start_key(input logic [127:0] k, input logic with_replay);
        wait_ready();
        expand(k);
        push_sched();
        key_in = k; key_valid = 1'b1; replay = with_replay;
        @(posedge clk); #2;
        key_valid = 1'b0; replay = 1'b0; key_in = $urandom();
        check("lat_valid", 128'(rk_valid), 128'd1);
        check("lat_idx", 128'(rk_idx), 128'd0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (key_ready !== 1'b1 && cyc < 300) begin @(posedge clk); #2; cyc++; end
        if (cyc >= 300) check("done_timeout", 128'(key_ready), 128'd1);
        check("queue_drained", 128'(q.size()), 128'd0);
    endtask

    task automatic wait_idx(input logic [3:0] target);
        int n = 0;
        while (!(rk_valid && rk_idx == target) && n < 100) begin @(posedge clk); #2; n++; end
        if (n >= 100) check("wait_idx", 128'(rk_idx), 128'(target));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_ready = 1'b1; replay = 1'b0;
        build_sbox();
        #2;
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_out", rk_out, 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        check("rst_rk_last", 128'(rk_last), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_key_ready", 128'(key_ready), 128'd1);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #2;

        // FIPS-197 A.1, continuous ready: 11 keys in 11 cycles.
        start_key(A1_KEY, 1'b0);
        wait_done(cyc);
        check("a1_cycles", 128'(cyc), 128'd11);
        check("a1_key_ready", 128'(key_ready), 128'd1);

`ifdef AES_KEYEXP_CACHE_EN
        expand(A1_KEY);
        push_sched();
        replay = 1'b1;
        @(posedge clk); #2;
        replay = 1'b0;
        check("replay_valid", 128'(rk_valid), 128'd1);
        wait_done(cyc);
        check("replay_cycles", 128'(cyc), 128'd11);
        rst = 1'b1; #1; rst = 1'b0;
        replay = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("replay_after_rst", 128'(rk_valid), 128'd0);
        end
        replay = 1'b0;
`else
        replay = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("replay_ignored", 128'(rk_valid), 128'd0);
            check("replay_idle", 128'(key_ready), 128'd1);
        end
        replay = 1'b0;
`endif

        // Backpressure: 3 stall cycles at idx 4, same sequence.
        stall_left = 3;
        start_key(A1_KEY, 1'b0);
        wait_done(cyc);
        check("bp_cycles", 128'(cyc), 128'd14);

        // Reset mid-schedule, then a fresh key.
        start_key(A1_KEY, 1'b0);
        wait_idx(4'd5);
        rst = 1'b1; #1;
        check("abort_rk_valid", 128'(rk_valid), 128'd0);
        check("abort_rk_out", rk_out, 128'd0);
        check("abort_rk_idx", 128'(rk_idx), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_key_ready", 128'(key_ready), 128'd1);
        q.delete();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #2;
        start_key(C_KEY, 1'b0);
        wait_done(cyc);

        // Second key offered while busy must not disturb the schedule.
        start_key(A1_KEY, 1'b0);
        key_in = OTHER; key_valid = 1'b1;
        wait_idx(4'd5);
        check("busy_in_emit", 128'(busy), 128'd1);
        key_valid = 1'b0;
        wait_done(cyc);

        // Random keys, random backpressure, replay sometimes raised alongside key_valid.
        rand_bp = 1'b1;
        for (int n = 0; n < 8; n++) begin
            start_key({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            wait_done(cyc);
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: key_valid  input  1  cipher key offered.
REQ-004 SHALL have port: key_ready  output  1  block can accept a key.
REQ-005 SHALL have port: key_in  input  128  AES-128 cipher key; bit 127 = first FIPS-197 byte MSB.
REQ-006 SHALL have port: rk_valid  output  1  round key valid.
REQ-007 SHALL have port: rk_ready  input  1  downstream accepts round key.
REQ-008 SHALL have port: rk_out  output  128  round key, same byte order as key_in.
REQ-009 SHALL have port: rk_idx  output  4  round index 0..10 of rk_out.
REQ-010 SHALL have port: rk_last  output  1  high when rk_valid and rk_idx==10.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: replay  input  1  re-emit cached schedule (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE and EMIT; key_ready = (state==IDLE), combinational.
REQ-014 SHALL accept a key on clk edge with key_valid && key_ready, then enter EMIT with rk_out=key_in, rk_idx=0, rk_valid=1 on the next cycle (1-cycle latency).
REQ-015 SHALL, on each edge with rk_valid && rk_ready and rk_idx<10, load rk_out with the FIPS-197 next round key computed from current rk_out and increment rk_idx; one key per accepted transfer, no bubbles.
REQ-016 SHALL compute next key as: w0'=w0^SubWord(RotWord(w3))^Rcon[idx+1], w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; Rcon = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
REQ-017 SHALL implement SubWord with four internal combinational AES S-box lookups (no external memory).
REQ-018 SHALL hold rk_out, rk_idx, rk_valid stable while rk_valid && !rk_ready.
REQ-019 SHALL, on accept of rk_idx==10, return to IDLE: rk_valid=0, key_ready=1 the next cycle; rk_out and rk_idx retain last value.
REQ-020 SHALL ignore key_valid while busy; key_in is not sampled.
REQ-021 SHALL give key_valid priority over replay when both are high in IDLE.

Reset
REQ-022 SHALL on rst asynchronously force: state=IDLE, rk_valid=0, rk_out=0, rk_idx=0, rk_last=0, busy=0; key_ready=1 once in IDLE.
REQ-023 SHALL abort any schedule in progress on rst; the first key after release is processed normally from rk_idx 0.

Configuration
REQ-024 SHALL support macro AES_KEYEXP_CACHE_EN.
REQ-025 SHALL with AES_KEYEXP_CACHE_EN: store each accepted round key in an 11x128 cache at rk_idx; set cache_ok when idx 10 is accepted; replay in IDLE with cache_ok and !key_valid enters EMIT and emits cache[0..10] under the same handshake/timing as REQ-014..019.
REQ-026 SHALL with AES_KEYEXP_CACHE_EN: clear cache_ok on rst, on key acceptance and on abort; replay with !cache_ok is ignored.
REQ-027 SHALL without AES_KEYEXP_CACHE_EN: omit cache storage; replay port present but ignored.

Verification
REQ-028 SHALL test FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0=key, idx1=a0fafe1788542cb123a339392a6c7605, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last, 11 consecutive cycles, key_ready=1 after.
REQ-029 SHALL test backpressure: same key, rk_ready low 3 cycles at idx 4 -> rk_out/rk_idx unchanged, sequence identical to REQ-028.
REQ-030 SHALL test rst pulse at idx 5 -> rk_valid=0, rk_out=0 immediately; new key 000102030405060708090a0b0c0d0e0f -> idx10=13111d7fe3944a17f307a78b4d2b30c5.
REQ-031 SHALL test key_valid with different key during EMIT -> ignored, schedule of first key completes unchanged.
REQ-032 SHALL test (with AES_KEYEXP_CACHE_EN) replay after REQ-028 -> identical 11 keys; replay after rst -> no rk_valid.
